// File: rtl/rgmii_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Package     : rgmii_pkg
//  Description : Shared types and constants for the RGMII TX forwarded-clock
//                pattern generator and its slot lookup table.
//  Revision    : 1.0  initial release
// ============================================================================
package rgmii_pkg;

    // Encodings match the speed_i input so a latched speed reads back directly.
    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } speed_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } gen_state_e;

    localparam int PERIOD_SLOTS_10M  = 50;
    localparam int PERIOD_SLOTS_100M = 5;

    // The reserved code 11 runs at gigabit rate.
    function automatic speed_e latch_speed(input logic [1:0] raw);
        speed_e v;
        case (raw)
            2'b00:   v = SPEED_10M;
            2'b01:   v = SPEED_100M;
            default: v = SPEED_1000M;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgmii_clk_slot_lut.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rgmii_clk_slot_lut
//  Description : Combinational map from (speed, slot index) to the 2-bit
//                forwarded-clock pattern of that slot, plus a flag marking the
//                last slot of the clock period. Bit 0 leaves the pins first.
//  Revision    : 1.0  initial release
// ============================================================================
module rgmii_clk_slot_lut
    import rgmii_pkg::*;
#(
    parameter int SLOT_CNT_W = 6,
    parameter int HALF_10M   = PERIOD_SLOTS_10M / 2,
    parameter int HALF_100M  = PERIOD_SLOTS_100M
) (
    input  speed_e                  i_speed,
    input  logic [SLOT_CNT_W-1:0]   i_slot_cnt,
    output logic [1:0]              o_pattern,
    output logic                    o_last_slot
);

    localparam logic [SLOT_CNT_W-1:0] c_half_10m      = SLOT_CNT_W'(HALF_10M);
    localparam logic [SLOT_CNT_W-1:0] c_last_10m      = SLOT_CNT_W'(2 * HALF_10M - 1);
    localparam logic [SLOT_CNT_W-1:0] c_last_100m     = SLOT_CNT_W'(HALF_100M - 1);
    localparam logic [SLOT_CNT_W:0]   c_half_100m_bit = (SLOT_CNT_W + 1)'(HALF_100M);

    // At 100M the period is an odd number of bits per half, so the high/low
    // split falls inside a slot; decide each bit from its index in the period.
    logic [SLOT_CNT_W:0] w_bit_idx_first;
    logic [SLOT_CNT_W:0] w_bit_idx_second;

    assign w_bit_idx_first  = {i_slot_cnt, 1'b0};
    assign w_bit_idx_second = {i_slot_cnt, 1'b1};

    // Decode the slot pattern and end-of-period flag for the selected speed.
    always_comb begin
        o_pattern   = 2'b01;
        o_last_slot = 1'b1;
        case (i_speed)
            SPEED_10M: begin
                o_pattern   = (i_slot_cnt < c_half_10m) ? 2'b11 : 2'b00;
                o_last_slot = (i_slot_cnt == c_last_10m);
            end
            SPEED_100M: begin
                o_pattern   = {(w_bit_idx_second < c_half_100m_bit),
                               (w_bit_idx_first  < c_half_100m_bit)};
                o_last_slot = (i_slot_cnt == c_last_100m);
            end
            default: begin
                // Gigabit: one slot per period, high bit first.
                o_pattern   = 2'b01;
                o_last_slot = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rgmii_tx_clk_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rgmii_tx_clk_pattern_gen
//  Description : Generates the 2-bit-per-slot forwarded TX clock pattern for
//                the downstream ODDR-style downsampler. Speed and enable are
//                only sampled on period boundaries so the clock never glitches.
//  Revision    : 1.0  initial release
// ============================================================================
module rgmii_tx_clk_pattern_gen
    import rgmii_pkg::*;
#(
    parameter int SLOT_CNT_W = 6,
    parameter int HALF_10M   = 25,
    parameter int HALF_100M  = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [1:0]  speed_i,
    input  logic        ready_i,
    output logic [1:0]  clk_setting_o,
    output logic        period_start_o,
    output logic [1:0]  speed_r_o,
    output logic        active_o
);

    gen_state_e              r_state;
    speed_e                  r_speed;
    logic [SLOT_CNT_W-1:0]   r_slot_cnt;
    logic                    r_last;        // current slot ends its period
    logic [1:0]              r_clk_setting;
    logic                    r_active;

    speed_e                  w_lut_speed;
    logic [SLOT_CNT_W-1:0]   w_lut_cnt;
    logic [1:0]              w_lut_pattern;
    logic                    w_lut_last;
    logic                    w_boundary;

    // The table is addressed with the slot that follows the current accept,
    // so the registered pattern is already valid when that slot is accepted.
    always_comb begin
        w_boundary  = (r_state == IDLE) || ((r_state == RUN) && r_last);
        w_lut_cnt   = '0;
        w_lut_speed = r_speed;
        if ((r_state == RUN) && !r_last) begin
            w_lut_cnt = r_slot_cnt + 1'b1;
        end
        if (w_boundary && en_i) begin
            w_lut_speed = latch_speed(speed_i);
        end
    end

    rgmii_clk_slot_lut #(
        .SLOT_CNT_W (SLOT_CNT_W),
        .HALF_10M   (HALF_10M),
        .HALF_100M  (HALF_100M)
    ) u_slot_lut (
        .i_speed     (w_lut_speed),
        .i_slot_cnt  (w_lut_cnt),
        .o_pattern   (w_lut_pattern),
        .o_last_slot (w_lut_last)
    );

    // Slot FSM: advances only when the downsampler accepts a slot.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_speed       <= SPEED_1000M;
            r_slot_cnt    <= '0;
            r_last        <= 1'b0;
            r_clk_setting <= 2'b00;
            r_active      <= 1'b0;
        end else if (ready_i) begin
            r_slot_cnt <= w_lut_cnt;
            r_speed    <= w_lut_speed;
            r_last     <= w_lut_last;
            case (r_state)
                IDLE: begin
                    if (en_i) begin
                        r_state       <= RUN;
                        r_clk_setting <= w_lut_pattern;
                        r_active      <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_last && !en_i) begin
                        // Period finished with enable gone: one low slot tail.
                        r_state       <= DRAIN;
                        r_clk_setting <= 2'b00;
                    end else begin
                        r_clk_setting <= w_lut_pattern;
                    end
                end
                DRAIN: begin
                    // Always pass through IDLE, even if enable is back.
                    r_state       <= IDLE;
                    r_clk_setting <= 2'b00;
                    r_active      <= 1'b0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_clk_setting <= 2'b00;
                    r_active      <= 1'b0;
                end
            endcase
        end
    end

    assign clk_setting_o  = r_clk_setting;
    assign speed_r_o      = r_speed;
    assign active_o       = r_active;
    assign period_start_o = ready_i && (r_state == RUN) && (r_slot_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_clk_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rgmii_tx_clk_pattern_gen
//  Description : Self-checking bench for the forwarded TX clock pattern
//                generator, with an independent bit-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgmii_tx_clk_pattern_gen;

    logic       clk_i;
    logic       reset_i;
    logic       en_i;
    logic [1:0] speed_i;
    logic       ready_i;
    logic [1:0] clk_setting_o;
    logic       period_start_o;
    logic [1:0] speed_r_o;
    logic       active_o;

    rgmii_tx_clk_pattern_gen #(
        .SLOT_CNT_W (6),
        .HALF_10M   (25),
        .HALF_100M  (5)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .speed_i        (speed_i),
        .ready_i        (ready_i),
        .clk_setting_o  (clk_setting_o),
        .period_start_o (period_start_o),
        .speed_r_o      (speed_r_o),
        .active_o       (active_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] clk;
        logic       ps;
        logic       act;
        logic [1:0] spd;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: 0 idle, 1 run, 2 drain
    int         m_state = 0;
    int         m_cnt   = 0;
    logic [1:0] m_spd   = 2'b10;

    logic [1:0] last_clk;
    logic       last_ps;
    int         ps_count;
    int         high_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Level of bit b within a period, from the clock frequency at 250 Mb/s.
    function automatic logic bit_level(input logic [1:0] spd, input int b);
        int per_bits;
        per_bits = (spd == 2'b00) ? 100 : (spd == 2'b01) ? 10 : 2;
        return ((b % per_bits) < (per_bits / 2));
    endfunction

    function automatic logic [1:0] ref_pattern(input logic [1:0] spd, input int s);
        return {bit_level(spd, 2 * s + 1), bit_level(spd, 2 * s)};
    endfunction

    function automatic int period_slots(input logic [1:0] spd);
        return (spd == 2'b00) ? 50 : (spd == 2'b01) ? 5 : 1;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.clk = (m_state == 1) ? ref_pattern(m_spd, m_cnt) : 2'b00;
        e.ps  = (m_state == 1) && (m_cnt == 0);
        e.act = (m_state != 0);
        e.spd = m_spd;
        return e;
    endfunction

    task automatic model_step();
        logic [1:0] lat;
        lat = (speed_i == 2'b11) ? 2'b10 : speed_i;
        case (m_state)
            0: if (en_i) begin m_state = 1; m_cnt = 0; m_spd = lat; end
            1: begin
                if (m_cnt == period_slots(m_spd) - 1) begin
                    m_cnt = 0;
                    if (en_i) m_spd = lat;
                    else      m_state = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    // One downsampler accept: ready high for one cycle, then low for one.
    task automatic accept();
        exp_t e;
        exp_t g;
        @(negedge clk_i);
        ready_i = 1'b1;
        e = model_expect();
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk("clk_setting",  32'(clk_setting_o),  32'(g.clk));
        chk("period_start", 32'(period_start_o), 32'(g.ps));
        chk("active",       32'(active_o),       32'(g.act));
        chk("speed_r",      32'(speed_r_o),      32'(g.spd));
        last_clk = clk_setting_o;
        last_ps  = period_start_o;
        if (period_start_o) ps_count++;
        if (clk_setting_o == 2'b11) high_count++;
        model_step();
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream;
        logic [1:0]  held_clk;
        logic [1:0]  held_spd;
        logic        held_act;

        reset_i = 1'b1;
        en_i    = 1'b0;
        speed_i = 2'b10;
        ready_i = 1'b0;
        #1;
        chk("rst_clk_setting",  32'(clk_setting_o),  32'd0);
        chk("rst_period_start", 32'(period_start_o), 32'd0);
        chk("rst_speed_r",      32'(speed_r_o),      32'd2);
        chk("rst_active",       32'(active_o),       32'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        // 1000M: 01 on every accept, period start on every accept
        en_i = 1'b1;
        ps_count = 0;
        for (int i = 0; i < 7; i++) accept();
        chk("t1_ps_count", 32'(ps_count), 32'd6);

        // 100M: the 1000M slot in flight finishes, then 5 high / 5 low bits
        speed_i = 2'b01;
        accept();
        stream = '0;
        for (int i = 0; i < 10; i++) begin
            accept();
            stream[2 * i]     = last_clk[0];
            stream[2 * i + 1] = last_clk[1];
        end
        chk("t2_bitstream", stream, 32'h0007_C1F);

        // 10M: latched at the end of the current 100M period
        speed_i = 2'b00;
        for (int i = 0; i < 5; i++) accept();
        ps_count   = 0;
        high_count = 0;
        for (int i = 0; i < 30; i++) accept();
        // Inputs change while the downsampler is stalled: nothing moves
        held_clk = clk_setting_o;
        held_spd = speed_r_o;
        held_act = active_o;
        en_i     = 1'b0;
        speed_i  = 2'b01;
        repeat (6) @(negedge clk_i);
        chk("hold_clk_setting", 32'(clk_setting_o), 32'(held_clk));
        chk("hold_speed_r",     32'(speed_r_o),     32'(held_spd));
        chk("hold_active",      32'(active_o),      32'(held_act));
        en_i    = 1'b1;
        speed_i = 2'b00;
        for (int i = 0; i < 70; i++) accept();
        chk("t3_ps_per_100", 32'(ps_count),   32'd2);
        chk("t3_high_slots", 32'(high_count), 32'd50);

        // Speed change at 10M slot 10 waits for the wrap
        for (int i = 0; i < 10; i++) accept();
        speed_i = 2'b01;
        for (int i = 0; i < 40; i++) accept();
        accept();
        chk("t4_first_100m_slot", 32'(last_clk), 32'd3);
        chk("t4_first_100m_ps",   32'(last_ps),  32'd1);

        // Enable dropped at 100M slot 1: finish period, drain, idle
        en_i = 1'b0;
        for (int i = 0; i < 6; i++) accept();
        #1;
        chk("t5_active_low", 32'(active_o),      32'd0);
        chk("t5_parked_low", 32'(clk_setting_o), 32'd0);

        // Enable returns during DRAIN: drain still completes, then idle restarts
        en_i = 1'b1;
        for (int i = 0; i < 5; i++) accept();
        en_i = 1'b0;
        accept();
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) accept();

        // Reserved speed code runs at gigabit
        speed_i = 2'b11;
        for (int i = 0; i < 6; i++) accept();

        // Asynchronous reset in the middle of a 10M period (slot 7)
        speed_i = 2'b00;
        for (int i = 0; i < 120 && !(m_state == 1 && m_spd == 2'b00 && m_cnt == 7); i++) accept();
        chk("t6_reached_slot7", 32'(m_state == 1 && m_spd == 2'b00 && m_cnt == 7), 32'd1);
        #1;
        chk("t6_pre_reset_clk", 32'(clk_setting_o), 32'd3);
        #1;
        reset_i = 1'b1;
        #1;
        chk("t6_async_clk",    32'(clk_setting_o), 32'd0);
        chk("t6_async_active", 32'(active_o),      32'd0);
        chk("t6_async_speed",  32'(speed_r_o),     32'd2);
        @(negedge clk_i);
        reset_i = 1'b0;
        m_state = 0;
        m_cnt   = 0;
        m_spd   = 2'b10;
        for (int i = 0; i < 4; i++) accept();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
